// File: rtl/spi_memory_pkg.sv
// Shared encodings for the SPI burst memory: FSM states and the R/W header bit.
package spi_memory_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        READ   = 2'd2,
        WRITE  = 2'd3
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/spi_memory_burst_input_conditioner.sv
// Synchroniser for one asynchronous SPI pin with aligned level and edge pulses.
// The level output is delayed one extra flop so it lines up with the pulses.
module input_conditioner #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic noisy_in,
    output logic conditioned,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   last;

    assign last = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync        <= {SYNC_STAGES{RESET_VAL}};
            conditioned <= RESET_VAL;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], noisy_in};
            conditioned <= last;
            rise_pulse  <= last & ~conditioned;
            fall_pulse  <= ~last & conditioned;
        end
    end

endmodule

// File: rtl/spi_memory_burst.sv
// SPI mode-0 slave memory: address, R/W bit, then words at auto-incremented
// addresses for as long as chip select stays low.
module spi_memory_burst
    import spi_memory_pkg::*;
#(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       miso_pin,
    output logic       miso_en,
    output logic [3:0] leds
);

    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam int CNT_MAX = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_WIDTH - 1);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise, mosi_fall;
    logic unused_pulses;

    input_conditioner #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sclk (
        .clk         (clk),
        .reset       (reset),
        .noisy_in    (sclk_pin),
        .conditioned (sclk_sync),
        .rise_pulse  (sclk_rise),
        .fall_pulse  (sclk_fall)
    );

    input_conditioner #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs (
        .clk         (clk),
        .reset       (reset),
        .noisy_in    (cs_pin),
        .conditioned (cs_sync),
        .rise_pulse  (cs_rise),
        .fall_pulse  (cs_fall)
    );

    input_conditioner #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_mosi (
        .clk         (clk),
        .reset       (reset),
        .noisy_in    (mosi_pin),
        .conditioned (mosi_sync),
        .rise_pulse  (mosi_rise),
        .fall_pulse  (mosi_fall)
    );

    assign unused_pulses = ^{cs_rise, mosi_rise, mosi_fall};

    state_t                 state, state_n;
    logic [ADDR_WIDTH-1:0]  addr, addr_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [DATA_WIDTH-1:0]  wsh, wsh_n;
    logic [DATA_WIDTH-1:0]  rsh, rsh_n;
    logic                   miso_q, miso_n;
    logic                   en_q, en_n;
    logic                   wr_pend, wr_pend_n;
    logic [ADDR_WIDTH-1:0]  wr_addr, wr_addr_n;
    logic [DATA_WIDTH-1:0]  wr_word, wr_word_n;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DATA_WIDTH-1:0]  rd_word;

    assign rd_word  = mem[addr];
    assign miso_pin = miso_q;
    assign miso_en  = en_q;
    assign leds     = {state, cs_sync, sclk_sync};

    always_comb begin
        state_n   = state;
        addr_n    = addr;
        cnt_n     = cnt;
        wsh_n     = wsh;
        rsh_n     = rsh;
        miso_n    = miso_q;
        en_n      = en_q;
        wr_pend_n = 1'b0;
        wr_addr_n = wr_addr;
        wr_word_n = wr_word;

        unique case (state)
            IDLE: begin
                en_n   = 1'b0;
                miso_n = 1'b0;
                if (cs_fall) begin
                    state_n = HEADER;
                    cnt_n   = '0;
                end
            end
            HEADER: begin
                if (sclk_rise) begin
                    if (cnt == HDR_LAST) begin
                        state_n = (mosi_sync == RW_READ) ? READ : WRITE;
                        cnt_n   = '0;
                    end else begin
                        addr_n = {addr[ADDR_WIDTH-2:0], mosi_sync};
                        cnt_n  = cnt + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (sclk_rise) begin
                    wsh_n = {wsh[DATA_WIDTH-2:0], mosi_sync};
                    if (cnt == WORD_LAST) begin
                        wr_pend_n = 1'b1;
                        wr_addr_n = addr;
                        wr_word_n = wsh_n;
                        addr_n    = addr + 1'b1;
                        cnt_n     = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            READ: begin
                // A fall at word start prefetches; later falls shift the next bit out.
                if (sclk_fall) begin
                    if (cnt == '0) begin
                        rsh_n  = rd_word;
                        miso_n = rd_word[DATA_WIDTH-1];
                        en_n   = 1'b1;
                    end else begin
                        rsh_n  = rsh << 1;
                        miso_n = rsh[DATA_WIDTH-2];
                    end
                end
                if (sclk_rise) begin
                    if (cnt == WORD_LAST) begin
                        addr_n = addr + 1'b1;
                        cnt_n  = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Deselect wins, but a write word completed this cycle still commits.
        if (cs_sync) begin
            state_n = IDLE;
            cnt_n   = '0;
            en_n    = 1'b0;
            miso_n  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr    <= '0;
            cnt     <= '0;
            wsh     <= '0;
            rsh     <= '0;
            miso_q  <= 1'b0;
            en_q    <= 1'b0;
            wr_pend <= 1'b0;
            wr_addr <= '0;
            wr_word <= '0;
        end else begin
            state   <= state_n;
            addr    <= addr_n;
            cnt     <= cnt_n;
            wsh     <= wsh_n;
            rsh     <= rsh_n;
            miso_q  <= miso_n;
            en_q    <= en_n;
            wr_pend <= wr_pend_n;
            wr_addr <= wr_addr_n;
            wr_word <= wr_word_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_pend) begin
            mem[wr_addr] <= wr_word;
        end
    end

endmodule

// File: tb/tb_spi_memory_burst.sv
// Directed bench: table of SPI frames against two configurations,
// plus a hand-written reset-during-read sequence.
module tb_spi_memory_burst;
    import spi_memory_pkg::*;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk, mosi, cs0, cs1;
    logic       miso0, en0, miso1, en1;
    logic [3:0] leds0, leds1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_memory_burst dut0 (
        .clk      (clk),
        .reset    (reset),
        .sclk_pin (sclk),
        .cs_pin   (cs0),
        .mosi_pin (mosi),
        .miso_pin (miso0),
        .miso_en  (en0),
        .leds     (leds0)
    );

    spi_memory_burst #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (16)
    ) dut1 (
        .clk      (clk),
        .reset    (reset),
        .sclk_pin (sclk),
        .cs_pin   (cs1),
        .mosi_pin (mosi),
        .miso_pin (miso1),
        .miso_en  (en1),
        .leds     (leds1)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] addr;
        logic        rw;
        int          nw;
        int          cut;
        logic [63:0] wd;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cs(input int sel, input logic v);
        if (sel == 1) cs1 = v;
        else cs0 = v;
    endtask

    task automatic bitx(input int sel, input logic b,
                        output logic q, output logic e);
        mosi = b;
        cyc(H);
        q = (sel == 1) ? miso1 : miso0;
        e = (sel == 1) ? en1 : en0;
        sclk = 1'b1;
        cyc(H);
        sclk = 1'b0;
    endtask

    task automatic frame(input int sel, input logic [15:0] addr,
                         input logic rw, input int nw, input int cut,
                         input logic [63:0] wd, output logic [63:0] rd,
                         output logic en_ok);
        int   aw, dw, nb, w, b;
        logic q, e;
        aw    = (sel == 1) ? 4 : 7;
        dw    = (sel == 1) ? 16 : 8;
        rd    = '0;
        en_ok = 1'b1;
        set_cs(sel, 1'b0);
        cyc(H);
        for (int i = aw - 1; i >= 0; i--) begin
            bitx(sel, addr[i], q, e);
            if (e !== 1'b0) en_ok = 1'b0;
        end
        bitx(sel, rw, q, e);
        if (e !== 1'b0) en_ok = 1'b0;
        nb = (cut >= 0) ? cut : nw * dw;
        for (int k = 0; k < nb; k++) begin
            w = k / dw;
            b = dw - 1 - (k % dw);
            bitx(sel, wd[16*w + b], q, e);
            rd[16*w + b] = q;
            if (e !== rw) en_ok = 1'b0;
        end
        cyc(H);
        set_cs(sel, 1'b1);
        cyc(2 * H);
    endtask

    initial begin
        logic [63:0] rd;
        logic        ok, q, e;
        logic [6:0]  a7;

        vecs[0]  = '{"wr01",  0, 16'h01, RW_WRITE, 1, -1, 64'hAA, 64'h0};
        vecs[1]  = '{"rd01",  0, 16'h01, RW_READ,  1, -1, 64'h0,  64'hAA};
        vecs[2]  = '{"wr7e",  0, 16'h7E, RW_WRITE, 3, -1, 64'h0033_0022_0011, 64'h0};
        vecs[3]  = '{"rd7e",  0, 16'h7E, RW_READ,  1, -1, 64'h0,  64'h11};
        vecs[4]  = '{"rd7f",  0, 16'h7F, RW_READ,  1, -1, 64'h0,  64'h22};
        vecs[5]  = '{"rd00",  0, 16'h00, RW_READ,  1, -1, 64'h0,  64'h33};
        vecs[6]  = '{"brd7e", 0, 16'h7E, RW_READ,  3, -1, 64'h0,  64'h0033_0022_0011};
        vecs[7]  = '{"wr10",  0, 16'h10, RW_WRITE, 1, -1, 64'hC3, 64'h0};
        vecs[8]  = '{"ab10",  0, 16'h10, RW_WRITE, 1,  5, 64'h55, 64'h0};
        vecs[9]  = '{"rd10",  0, 16'h10, RW_READ,  1, -1, 64'h0,  64'hC3};
        vecs[10] = '{"wr16",  1, 16'hF,  RW_WRITE, 2, -1, 64'h1234_BEEF, 64'h0};
        vecs[11] = '{"rd16f", 1, 16'hF,  RW_READ,  1, -1, 64'h0,  64'hBEEF};
        vecs[12] = '{"rd160", 1, 16'h0,  RW_READ,  1, -1, 64'h0,  64'h1234};
        vecs[13] = '{"brd16", 1, 16'hF,  RW_READ,  2, -1, 64'h0,  64'h1234_BEEF};

        reset = 1'b1;
        cs0   = 1'b1;
        cs1   = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        cyc(4);
        check("reset0", {miso0, en0, leds0}, {2'b00, 4'b0010});
        check("reset1", {miso1, en1, leds1}, {2'b00, 4'b0010});
        reset = 1'b0;
        cyc(4);

        for (int i = 0; i < 14; i++) begin
            frame(vecs[i].sel, vecs[i].addr, vecs[i].rw, vecs[i].nw,
                  vecs[i].cut, vecs[i].wd, rd, ok);
            check({vecs[i].name, "_en"}, {63'd0, ok}, 64'd1);
            if (vecs[i].rw == RW_READ)
                check(vecs[i].name, rd, vecs[i].exp);
            if (vecs[i].sel == 1)
                check({vecs[i].name, "_post"}, {miso1, en1, leds1}, {2'b00, 4'b0010});
            else
                check({vecs[i].name, "_post"}, {miso0, en0, leds0}, {2'b00, 4'b0010});
        end

        // Reset while the fourth data bit of a read is on the wire.
        frame(0, 16'h20, RW_WRITE, 1, -1, 64'h5A, rd, ok);
        a7  = 7'h20;
        cs0 = 1'b0;
        cyc(H);
        for (int i = 6; i >= 0; i--) bitx(0, a7[i], q, e);
        bitx(0, RW_READ, q, e);
        for (int i = 0; i < 3; i++) bitx(0, 1'b0, q, e);
        mosi = 1'b0;
        cyc(H);
        sclk = 1'b1;
        cyc(3);
        check("rst_pre", {miso0, en0}, 2'b11);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("rst_mid", {miso0, en0, leds0}, {2'b00, 4'b0010});
        cyc(H);
        sclk = 1'b0;
        cyc(H);
        cs0 = 1'b1;
        cyc(2 * H);
        check("rst_idle", {miso0, en0, leds0}, {2'b00, 4'b0010});

        frame(0, 16'h20, RW_READ, 1, -1, 64'h0, rd, ok);
        check("rst_rd20", rd, 64'h5A);
        check("rst_rd20_en", {63'd0, ok}, 64'd1);
        frame(0, 16'h01, RW_READ, 1, -1, 64'h0, rd, ok);
        check("rst_rd01", rd, 64'hAA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_memory_burst.md
Name: spi_memory_burst

Overview:
- Parametrised SPI-slave memory; next generation of the lab's 7-bit-address, 8-bit-data SPI memory.
- Generalised in address/data width; adds burst mode: while chip select stays low, consecutive words go to auto-incremented addresses.
- Sits between the board SPI pins (sclk/cs/mosi/miso) and an internal register-array memory, clocked by the FPGA clock `clk`.
- SPI mode 0, MSB first: master changes mosi on sclk falling edge and samples miso on rising edge.

Parameters:
- ADDR_WIDTH, 7: address bits per transaction; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8: bits per memory word.
- SYNC_STAGES, 2: flip-flop stages synchronising each SPI input pin to `clk` (minimum 2).

Ports:
- clk  input  1  FPGA clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sclk_pin  input  1  SPI clock from master (asynchronous to clk).
- cs_pin  input  1  SPI chip select, active low.
- mosi_pin  input  1  master out, slave in.
- miso_pin  output  1  slave out, master in.
- miso_en  output  1  high while slave drives miso (tri-state enable at top level).
- leds  output  4  debug: {state[1:0], cs_sync, sclk_sync}.

Behaviour:
- Reset values: miso_pin=0, miso_en=0, leds={IDLE,1,0}; state=IDLE; counters/shift regs=0. Memory contents are NOT reset.
- Reset mid-transaction: IDLE next cycle; any partially shifted write is discarded.
- Input conditioning: each pin passes through SYNC_STAGES flops. sclk_rise/sclk_fall are one-cycle pulses from the synchronised sclk. Latency pin->pulse = SYNC_STAGES+1 clk cycles. Required: sclk half-period >= SYNC_STAGES+3 clk cycles.
- Frame: ADDR_WIDTH address bits (MSB first), then 1 R/W bit (1=read, 0=write), then N>=1 data words of DATA_WIDTH bits, MSB first. All inputs are sampled on sclk_rise.
- IDLE:
  - miso_en=0.
  - cs_sync falling -> HEADER; bit counter=0.
- HEADER:
  - Shift mosi into addr on each sclk_rise.
  - On rise number ADDR_WIDTH+1, the sampled bit selects READ (1) or WRITE (0); data counter=0.
- WRITE:
  - Shift mosi into wdata on each sclk_rise.
  - On rise number DATA_WIDTH: mem[addr] <= word one clk later; addr <= addr+1 mod DEPTH; counter=0; stay in WRITE.
- READ:
  - On each sclk_fall with counter==0: load shift reg from mem[addr]; drive MSB on miso_pin; miso_en=1.
  - On other sclk_fall: shift, drive next bit.
  - Count each sclk_rise. On rise number DATA_WIDTH: addr <= addr+1 mod DEPTH; counter=0. Next word is prefetched on the following sclk_fall.
  - miso_pin is stable for the whole high phase of sclk.
- cs_sync high in any state:
  - -> IDLE next cycle; miso_en=0, miso_pin=0.
  - A partial write word is discarded; completed words are kept.
  - cs rising during HEADER aborts with no effect.
- Address wrap: DEPTH-1 increments to 0; no error flag.
- Simultaneous cs rise and final write sclk_rise in the same cycle: the write commits.
- sclk edges while cs high are ignored.

Decomposition:
- Package spi_memory_pkg: state encoding localparams (IDLE=0, HEADER=1, READ=2, WRITE=3) and the RW_READ=1 / RW_WRITE=0 constants.
- Sub-module input_conditioner: parameter SYNC_STAGES; ports clk, reset, noisy_in; outputs conditioned, rise_pulse, fall_pulse. Instantiated three times (sclk, cs, mosi).
- Top module holds the FSM, counters, shift registers and memory array.

Test Plan:
- Single write then read: write 0xAA to addr 0x01, cs high, then read addr 0x01 -> master captures 0xAA; miso_en high only during data phase.
- Burst write 0x11,0x22,0x33 starting at addr 0x7E in one cs-low frame, then three single reads -> 0x7E=0x11, 0x7F=0x22, 0x00=0x33 (wrap).
- Burst read of the same three words from 0x7E in one frame -> captures 0x11,0x22,0x33 with no gaps; address wraps to 0x00.
- Abort: write 0x55 to addr 0x10 (earlier 0xC3), cs rises after 5 data bits -> read of 0x10 returns 0xC3; state IDLE, miso_en=0.
- Reset mid-read: assert reset during data bit 3 -> next cycle miso_pin=0, miso_en=0, leds[3:2]=IDLE; a subsequent full read returns the stored value.
- Parameter sweep ADDR_WIDTH=4, DATA_WIDTH=16: write 0xBEEF to addr 0xF, then 0x1234 (wraps to 0x0) -> reads return 0xBEEF, 0x1234.
